// File: rtl/mem_stage_pkg.sv
// Shared definitions for the RV32IM memory-access stage: funct3 codes, FSM
// encoding, byte-enable constants and the access-size decode.
package mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_e;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_B0   = 4'b0001;
    localparam logic [3:0] BE_H_LO = 4'b0011;
    localparam logic [3:0] BE_H_HI = 4'b1100;
    localparam logic [3:0] BE_W    = 4'b1111;

    // Unsigned byte/half codes exist only for loads; a store with them is a word.
    function automatic size_e access_size(input logic [2:0] f3, input logic is_store);
        size_e sz;
        sz = SZ_W;
        case (f3)
            F3_B:    sz = SZ_B;
            F3_H:    sz = SZ_H;
            F3_W:    sz = SZ_W;
            F3_BU:   sz = is_store ? SZ_W : SZ_B;
            F3_HU:   sz = is_store ? SZ_W : SZ_H;
            default: sz = SZ_W;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the memory
// word and sign- or zero-extends it according to funct3.
module load_align
    import mem_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0] rdata_i,
    input  logic [1:0]   addr_lo_i,
    input  logic [2:0]   funct3_i,
    output logic [W-1:0] result_o
);

    logic signed [7:0]   byte_s;
    logic signed [15:0]  half_s;
    logic signed [W-1:0] byte_ext;
    logic signed [W-1:0] half_ext;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_s = rdata_i[7:0];
            2'd1:    byte_s = rdata_i[15:8];
            2'd2:    byte_s = rdata_i[23:16];
            default: byte_s = rdata_i[31:24];
        endcase
        half_s   = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        byte_ext = W'(byte_s);
        half_ext = W'(half_s);

        case (access_size(funct3_i, 1'b0))
            SZ_B:    result_o = (funct3_i == F3_BU) ? {{(W-8){1'b0}}, byte_s}
                                                    : $unsigned(byte_ext);
            SZ_H:    result_o = (funct3_i == F3_HU) ? {{(W-16){1'b0}}, half_s}
                                                    : $unsigned(half_ext);
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32IM memory-access stage: ALU pass-through or byte/half/word load/store over
// a req/gnt/rvalid port. Optional macro MEM_MISALIGN_TRAP_EN enables the misaligned check.
module mem_stage
    import mem_pkg::*;
#(
    parameter int W = 32,
    parameter int R = 5
) (
    input  logic         clk,
    input  logic         a_reset_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_alu_result,
    input  logic [W-1:0] in_store_data,
    input  logic [R-1:0] in_rd,
    input  logic         in_useRd,
    input  logic         in_memRead,
    input  logic         in_memWrite,
    input  logic [2:0]   in_funct3,
    output logic         dmem_req,
    output logic         dmem_we,
    output logic [3:0]   dmem_be,
    output logic [W-1:0] dmem_addr,
    output logic [W-1:0] dmem_wdata,
    input  logic         dmem_gnt,
    input  logic         dmem_rvalid,
    input  logic [W-1:0] dmem_rdata,
    output logic [W-1:0] out_result,
    output logic [R-1:0] out_rd,
    output logic         out_useRd,
    output logic         out_stall,
    output logic         out_misaligned
);

    state_e       state_q;
    logic [W-1:0] addr_q;
    logic [W-1:0] wdata_q;
    logic [3:0]   be_q;
    logic         we_q;
    logic [R-1:0] rd_q;
    logic         useRd_q;
    logic [2:0]   funct3_q;
    logic         is_load_q;

    size_e        in_size;
    logic         is_mem;
    logic         misaligned;
    logic         accept;
    logic [3:0]   be_d;
    logic [W-1:0] wdata_d;
    logic [W-1:0] load_result;

    // Decode of the incoming instruction while the stage is idle.
    always_comb begin
        in_size = access_size(in_funct3, in_memWrite);
        is_mem  = in_valid && (in_memRead || in_memWrite);
        case (in_size)
            SZ_B: begin
                be_d    = BE_B0 << in_alu_result[1:0];
                wdata_d = {4{in_store_data[7:0]}};
            end
            SZ_H: begin
                be_d    = in_alu_result[1] ? BE_H_HI : BE_H_LO;
                wdata_d = {2{in_store_data[15:0]}};
            end
            default: begin
                be_d    = BE_W;
                wdata_d = in_store_data;
            end
        endcase
`ifdef MEM_MISALIGN_TRAP_EN
        misaligned = is_mem && (state_q == ST_IDLE)
                     && (((in_size == SZ_H) && in_alu_result[0])
                      || ((in_size == SZ_W) && (in_alu_result[1:0] != 2'b00)));
`else
        misaligned = 1'b0;
`endif
        accept = (state_q == ST_IDLE) && is_mem && !misaligned;
    end

    always_ff @(posedge clk or negedge a_reset_n) begin
        if (!a_reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= BE_NONE;
            we_q      <= 1'b0;
            rd_q      <= '0;
            useRd_q   <= 1'b0;
            funct3_q  <= '0;
            is_load_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        addr_q    <= in_alu_result;
                        wdata_q   <= wdata_d;
                        be_q      <= be_d;
                        we_q      <= in_memWrite;
                        rd_q      <= in_rd;
                        useRd_q   <= in_useRd;
                        funct3_q  <= in_funct3;
                        is_load_q <= in_memRead;
                        state_q   <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem_gnt) begin
                        state_q <= is_load_q ? ST_WAIT : ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (dmem_rvalid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Request fields come straight from registers so they stay stable until gnt.
    assign dmem_req   = (state_q == ST_REQ);
    assign dmem_we    = dmem_req && we_q;
    assign dmem_be    = dmem_req ? be_q : BE_NONE;
    assign dmem_addr  = {addr_q[W-1:2], 2'b00};
    assign dmem_wdata = wdata_q;

    load_align #(
        .W(W)
    ) u_load_align (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (addr_q[1:0]),
        .funct3_i  (funct3_q),
        .result_o  (load_result)
    );

    always_comb begin
        out_result     = in_alu_result;
        out_rd         = in_rd;
        out_useRd      = in_valid && in_useRd;
        out_stall      = 1'b0;
        out_misaligned = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (misaligned) begin
                    out_useRd      = 1'b0;
                    out_misaligned = 1'b1;
                end else if (accept) begin
                    out_useRd = 1'b0;
                    out_stall = 1'b1;
                end
            end
            ST_REQ: begin
                out_result = load_result;
                out_rd     = rd_q;
                out_useRd  = 1'b0;
                out_stall  = !(dmem_gnt && !is_load_q);
            end
            ST_WAIT: begin
                out_result = load_result;
                out_rd     = rd_q;
                out_useRd  = dmem_rvalid && useRd_q;
                out_stall  = !dmem_rvalid;
            end
            default: begin
                out_useRd = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32IM pipeline: passes ALU results through, or performs byte/half/word loads and stores on the data-memory port via a req/gnt/rvalid handshake. Its result/rd/useRd outputs feed the MEM/WB pipeline register directly. While an access is outstanding it stalls the upstream pipeline and emits bubbles (useRd=0).

## Interface
- W, 32, data/address width
- R, 5, register-index width
- clk  in  1  clock
- a_reset_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction present in this stage
- in_alu_result  in  W  ALU result / effective address
- in_store_data  in  W  rs2 value for stores
- in_rd  in  R  destination register
- in_useRd  in  1  instruction writes rd
- in_memRead / in_memWrite  in  1 each  load / store (never both)
- in_funct3  in  3  access size/sign
- dmem_req  out  1  request valid
- dmem_we  out  1  1 = store
- dmem_be  out  4  byte enables
- dmem_addr  out  W  word-aligned address
- dmem_wdata  out  W  lane-replicated store data
- dmem_gnt  in  1  request accepted
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  W  load data
- out_result  out  W  to MEM/WB result
- out_rd  out  R  to MEM/WB rd
- out_useRd  out  1  to MEM/WB useRd
- out_stall  out  1  hold upstream stages
- out_misaligned  out  1  misaligned-access pulse

## Operation
- FSM states IDLE, REQ, WAIT; reset → IDLE. All internal regs (addr, wdata, rd, useRd, funct3, is_load) reset to 0.
- IDLE, non-memory instruction or !in_valid: out_result=in_alu_result, out_rd=in_rd, out_useRd=in_valid&in_useRd, out_stall=0, dmem_req=0.
- IDLE, aligned memory instruction: latch inputs, → REQ; out_stall=1, out_useRd=0.
- REQ: dmem_req=1 with registered addr/we/be/wdata, held stable until gnt. out_stall=1 except on the store-gnt cycle.
- REQ, gnt, store → IDLE; that cycle out_stall=0, out_useRd=0.
- REQ, gnt, load → WAIT.
- WAIT: out_stall=1, dmem_req=0. On rvalid: out_result=extended load data, out_rd/out_useRd from latched values, out_stall=0, → IDLE.
- rvalid is ignored outside WAIT. The memory never asserts rvalid in the gnt cycle.
- Upstream holds inputs while out_stall=1. The stage uses only latched values after IDLE.
- funct3 loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Stores: 000 SB, 001 SH, 010 SW. Other codes are treated as word.
- dmem_addr={addr[W-1:2],2'b00}.
- SB: be=4'b0001<<addr[1:0], wdata={4{byte}}. SH: be=addr[1]?1100:0011, wdata={2{half}}. SW: be=1111.
- Load extract: byte lane addr[1:0], half lane addr[1]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Reset mid-access: immediate return to IDLE, dmem_req drops asynchronously, pending rvalid discarded.

## Timing
- Reset values: dmem_req=0, dmem_we=0, dmem_be=0, out_misaligned=0. out_stall/out_useRd=0 when in_valid=0. Data outputs are 0 from registers; pass-through values follow inputs.
- Pass-through: 0 cycles (combinational), registered by MEM/WB.
- Store: minimum 2 cycles (arrival, gnt). Each gnt wait cycle adds 1.
- Load: minimum 3 cycles (arrival, gnt, rvalid). Each wait cycle adds 1.
- A new instruction is accepted on the cycle after stall deasserts.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: in IDLE, a half access at odd addr or a word access with addr[1:0]≠0 issues no request. out_misaligned=1 for that cycle, out_useRd=0, out_stall=0.
- Undefined: no check. Low address bits are ignored for lane selection beyond the access size (half uses addr[1], word uses none). out_misaligned is tied 0.

## Structure
- Package mem_pkg: funct3 load/store constants, FSM state encoding (2-bit), byte-enable constants.
- Sub-module load_align: combinational lane select plus sign/zero extension (rdata, addr[1:0], funct3 → W-bit result).

## Test plan
- ALU op, in_alu_result=0x1234_5678, rd=5, useRd=1 → same-cycle out_result=0x12345678, out_rd=5, out_useRd=1, out_stall=0.
- SB addr=0x103, data=0xAB, gnt after 2 wait cycles → dmem_addr=0x100, be=1000, wdata=0xABABABAB. Stall held 3 cycles, then useRd=0.
- LB addr=0x202, rdata=0x0080_0000 → out_result=0xFFFF_FF80. Same with LBU → 0x0000_0080. Minimum latency 3 cycles.
- LH addr=0x2, rdata=0x8001_0000 → 0xFFFF_8001. LW with rvalid delayed 4 cycles → stall held throughout, out_useRd only on the rvalid cycle.
- With MEM_MISALIGN_TRAP_EN: LW addr=0x6 → no dmem_req, out_misaligned=1 for one cycle, out_useRd=0.
- a_reset_n low during WAIT, then rvalid after release → FSM in IDLE, rvalid ignored, no writeback.
